// File: rtl/spike_event_dispatcher_pkg.sv
// Shared accelerator constants for the spike event path.
package spike_event_dispatcher_pkg;

  localparam int unsigned NUM_LANES_DEF  = 10;
  localparam int unsigned ADDR_W_DEF     = 12;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  // Increment modulo n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/spike_addr_fifo.sv
// Synchronous address FIFO with registered occupancy and full/empty flags.
module spike_addr_fifo #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Forced to zero when empty so reset/flush never exposes stale storage.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && reset_n && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spike_event_dispatcher.sv
// Per-lane spike capture slots with a round-robin arbiter feeding an address FIFO.
module spike_event_dispatcher
  import spike_event_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [NUM_LANES-1:0]          lane_valid,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    overflow_count,
  output logic                          idle
);

  localparam int unsigned RrW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned DropW = $clog2(NUM_LANES + 1);

  logic [NUM_LANES-1:0] pend_q;
  logic [ADDR_W-1:0]    slot_addr_q [NUM_LANES];
  logic [RrW-1:0]       rr_q;
  logic [7:0]           ovf_q, ovf_d;

  logic                 gnt_valid;
  logic [RrW-1:0]       gnt_idx;
  logic [NUM_LANES-1:0] cap;
  logic [DropW-1:0]     drops;
  logic [15:0]          ovf_sum;
  logic                 fifo_full, fifo_empty;

  // Round-robin pick: scan from the far end so the lowest offset from rr_q wins.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (!fifo_full) begin
      for (int off = int'(NUM_LANES) - 1; off >= 0; off--) begin
        idx = int'(rr_q) + off;
        if (idx >= int'(NUM_LANES)) idx = idx - int'(NUM_LANES);
        if (pend_q[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = RrW'(idx);
        end
      end
    end
  end

  // Capture into a free or just-granted slot; everything else is a drop.
  always_comb begin
    drops = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      cap[i] = lane_valid[i] && (!pend_q[i] || (gnt_valid && gnt_idx == RrW'(i)));
      if (lane_valid[i] && !cap[i]) drops = drops + DropW'(1);
    end
    ovf_sum = {8'b0, ovf_q} + 16'(drops);
    ovf_d   = (ovf_sum > 16'd255) ? 8'hFF : ovf_sum[7:0];
  end

  // Slot flags, arbiter pointer and drop counter; clear spares the counter.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= '0;
    end else if (clear) begin
      pend_q <= '0;
      rr_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (cap[i])                                  pend_q[i] <= 1'b1;
        else if (gnt_valid && gnt_idx == RrW'(i))    pend_q[i] <= 1'b0;
      end
      if (gnt_valid) rr_q <= RrW'(wrap_inc(int'(gnt_idx), NUM_LANES));
      ovf_q <= ovf_d;
    end
  end

  // Slot address registers, only meaningful while the flag is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (cap[i]) slot_addr_q[i] <= lane_addr[i*ADDR_W +: ADDR_W];
    end
  end

  spike_addr_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .reset_n   (reset_n),
    .flush     (clear),
    .push      (gnt_valid),
    .push_data (slot_addr_q[gnt_idx]),
    .pop       (out_valid && out_ready),
    .head      (out_addr),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid      = !fifo_empty;
  assign overflow_count = ovf_q;
  assign idle           = !(|pend_q) && fifo_empty;

endmodule
